// File: rtl/tap_product_filter.sv
// Iterative tap filter: keeps the last TAPS samples and returns their product or sum.
// Optional macro CHANGE_DETECT_EN drops accepted samples equal to the newest tap.
module tap_product_filter #(
  parameter int DW   = 8,
  parameter int TAPS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      in,
  input  logic               in_en,
  input  logic               mode,
  output logic               in_rdy,
  output logic [DW*TAPS-1:0] out,
  output logic               out_en
);

  localparam int AW = DW * TAPS;
  localparam int IW = $clog2(TAPS) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   tap_q [TAPS];
  logic [AW-1:0]   acc_q;
  logic [IW-1:0]   idx_q;
  logic            mode_q;
  logic [AW-1:0]   out_q;
  logic            out_en_q;

  logic            dup;
  logic            accept;
  logic            last_step;
  logic [DW-1:0]   tap_sel;

  // One accumulation step; the product fits in AW bits for unsigned operands.
  function automatic logic [AW-1:0] acc_step(input logic [AW-1:0] acc,
                                             input logic [DW-1:0] t,
                                             input logic          sum);
    if (sum) return acc + AW'(t);
    else     return acc * AW'(t);
  endfunction

`ifdef CHANGE_DETECT_EN
  assign dup = (in == tap_q[0]);
`else
  assign dup = 1'b0;
`endif

  assign in_rdy    = (state_q == IDLE);
  assign accept    = in_rdy && in_en && !dup;
  assign last_step = (idx_q == IW'(TAPS - 1));
  assign out       = out_q;
  assign out_en    = out_en_q;

  always_comb begin
    tap_sel = tap_q[0];
    for (int k = 0; k < TAPS; k++) begin
      if (idx_q == IW'(k)) tap_sel = tap_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (TAPS > 1) ? CALC : DONE;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      out_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tap_q[0] <= in;
            for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
            acc_q  <= AW'(in);
            idx_q  <= IW'(1);
            mode_q <= mode;
          end
        end
        CALC: begin
          acc_q <= acc_step(acc_q, tap_sel, mode_q);
          idx_q <= idx_q + IW'(1);
        end
        DONE: begin
          out_q    <= acc_q;
          out_en_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
